pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline control block.
//   - state_e        : control FSM states (RUN, DIV, FLUSH)
//   - DIV_CYCLES_DEF : default number of cycles the iterative divider holds EX
//   - CNT_W_DEF      : divide counter width for the default cycle count
//   - cnt_width()    : counter width for an arbitrary cycle count (min 1 bit)
//   - ctrl_out_t     : bundle of every control output, driven as one unit
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DIV_CYCLES_DEF = 32;

  // A single-cycle divider still needs a 1-bit counter to hold the value 0.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIV_CYCLES_DEF);

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic flush_wb;
    logic div_run;
    logic div_done;
    logic exc_redirect;
  } ctrl_out_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational detection of the two hazards that need a stall.
//   Ports:
//     id_rs_i, id_rt_i  : source registers of the ID instruction
//     id_branch_i       : ID instruction reads registers in ID (branch/jr/jalr)
//     ex_rmem_i         : EX instruction is a load
//     ex_waddr_i        : EX destination register
//     mem_rmem_i        : MEM instruction is a load
//     mem_waddr_i       : MEM destination register
//     load_use_o        : load in EX feeds the ID instruction
//     branch_o          : load in MEM feeds a branch resolved in ID
// ---------------------------------------------------------------------------
module hazard_detect (
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_branch_i,
  input  logic       ex_rmem_i,
  input  logic [4:0] ex_waddr_i,
  input  logic       mem_rmem_i,
  input  logic [4:0] mem_waddr_i,
  output logic       load_use_o,
  output logic       branch_o
);

  logic [4:0] src [2];
  logic [1:0] ex_hit;
  logic [1:0] mem_hit;

  assign src[0] = id_rs_i;
  assign src[1] = id_rt_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi]  = (src[gi] == ex_waddr_i);
      assign mem_hit[gi] = (src[gi] == mem_waddr_i);
    end
  endgenerate

  // $zero is hard-wired, so a "write" to it never creates a dependency.
  assign load_use_o = ex_rmem_i && (ex_waddr_i != 5'd0) && (|ex_hit);
  assign branch_o   = id_branch_i && mem_rmem_i && (mem_waddr_i != 5'd0) && (|mem_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush controller for a 5-stage pipeline with an iterative divider.
//   Priority: exception/eret > divide > load-use/branch hazard > nothing.
//   Parameter:
//     DIV_CYCLES     : cycles the divider occupies EX
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-low reset
//     id_*/ex_*/mem_*: hazard inputs (see hazard_detect)
//     ex_div_i       : EX instruction is div/divu
//     exc_valid_i    : MEM stage reports an exception or eret
//     stall_*_o      : hold PC, IF/ID, ID/EX
//     flush_*_o      : bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
//     div_run_o      : divider enable
//     div_done_o     : pulse on the divider's last cycle (HI/LO write)
//     exc_redirect_o : PC takes the exception/eret vector
//   All outputs are combinational from state, counter and current inputs.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_branch_i,
  input  logic       ex_rmem_i,
  input  logic [4:0] ex_waddr_i,
  input  logic       mem_rmem_i,
  input  logic [4:0] mem_waddr_i,
  input  logic       ex_div_i,
  input  logic       exc_valid_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic       flush_mem_o,
  output logic       flush_wb_o,
  output logic       div_run_o,
  output logic       div_done_o,
  output logic       exc_redirect_o
);

  localparam int             CNT_W    = cnt_width(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  ctrl_out_t        ctrl;
  logic             load_use;
  logic             branch_haz;

  hazard_detect u_hazard_detect (
    .id_rs_i     (id_rs_i),
    .id_rt_i     (id_rt_i),
    .id_branch_i (id_branch_i),
    .ex_rmem_i   (ex_rmem_i),
    .ex_waddr_i  (ex_waddr_i),
    .mem_rmem_i  (mem_rmem_i),
    .mem_waddr_i (mem_waddr_i),
    .load_use_o  (load_use),
    .branch_o    (branch_haz)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    ctrl       = '0;
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (exc_valid_i) begin
      // Kill everything younger than the faulting instruction, including an
      // in-flight divide; the divider result is simply never written.
      ctrl.flush_id     = 1'b1;
      ctrl.flush_ex     = 1'b1;
      ctrl.flush_mem    = 1'b1;
      ctrl.flush_wb     = 1'b1;
      ctrl.exc_redirect = 1'b1;
      state_next        = ST_FLUSH;
      cnt_next          = '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (ex_div_i) begin
            // Entry cycle behaves like a DIV busy cycle.
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.flush_mem = 1'b1;
            ctrl.div_run   = 1'b1;
            state_next     = ST_DIV;
            cnt_next       = '0;
          end else if (load_use || branch_haz) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
          end
        end

        ST_DIV: begin
          ctrl.div_run = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Last iteration: release the pipe so the div moves on to MEM.
            ctrl.div_done = 1'b1;
            state_next    = ST_RUN;
            cnt_next      = '0;
          end else begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.flush_mem = 1'b1;
            cnt_next       = cnt_reg + CNT_W'(1);
          end
        end

        ST_FLUSH: begin
          // The IF/ID register still holds a fetch from the old path.
          ctrl.flush_id = 1'b1;
          state_next    = ST_RUN;
        end

        default: begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign stall_if_o     = ctrl.stall_if;
  assign stall_id_o     = ctrl.stall_id;
  assign stall_ex_o     = ctrl.stall_ex;
  assign flush_id_o     = ctrl.flush_id;
  assign flush_ex_o     = ctrl.flush_ex;
  assign flush_mem_o    = ctrl.flush_mem;
  assign flush_wb_o     = ctrl.flush_wb;
  assign div_run_o      = ctrl.div_run;
  assign div_done_o     = ctrl.div_done;
  assign exc_redirect_o = ctrl.exc_redirect;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl. Each test builds a list of
//   per-cycle stimulus steps with the expected output vector; the expected
//   vector is queued when the step is driven and compared at the falling
//   edge. Output vector bit order:
//   {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, flush_wb,
//    div_run, div_done, exc_redirect}
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int DIV_N = 32;

  localparam logic [9:0] E_IDLE = 10'b0000000000;
  localparam logic [9:0] E_HAZ  = 10'b1100100000; // stall_if, stall_id, flush_ex
  localparam logic [9:0] E_DIVB = 10'b1110010100; // stalls x3, flush_mem, div_run
  localparam logic [9:0] E_DONE = 10'b0000000110; // div_run, div_done
  localparam logic [9:0] E_EXC  = 10'b0001111001; // four flushes, exc_redirect
  localparam logic [9:0] E_FLSH = 10'b0001000000; // flush_id

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_waddr_i = '0, mem_waddr_i = '0;
  logic       id_branch_i = 1'b0, ex_rmem_i = 1'b0, mem_rmem_i = 1'b0;
  logic       ex_div_i = 1'b0, exc_valid_i = 1'b0;
  logic       stall_if_o, stall_id_o, stall_ex_o;
  logic       flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o;
  logic       div_run_o, div_done_o, exc_redirect_o;

  pipeline_ctrl #(.DIV_CYCLES(DIV_N)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_branch_i    (id_branch_i),
    .ex_rmem_i      (ex_rmem_i),
    .ex_waddr_i     (ex_waddr_i),
    .mem_rmem_i     (mem_rmem_i),
    .mem_waddr_i    (mem_waddr_i),
    .ex_div_i       (ex_div_i),
    .exc_valid_i    (exc_valid_i),
    .stall_if_o     (stall_if_o),
    .stall_id_o     (stall_id_o),
    .stall_ex_o     (stall_ex_o),
    .flush_id_o     (flush_id_o),
    .flush_ex_o     (flush_ex_o),
    .flush_mem_o    (flush_mem_o),
    .flush_wb_o     (flush_wb_o),
    .div_run_o      (div_run_o),
    .div_done_o     (div_done_o),
    .exc_redirect_o (exc_redirect_o)
  );

  always #5 clk_i = ~clk_i;

  logic [9:0] outs;
  assign outs = {stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o,
                 flush_mem_o, flush_wb_o, div_run_o, div_done_o, exc_redirect_o};

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       exr;
    logic [4:0] exw;
    logic       memr;
    logic [4:0] memw;
    logic       div;
    logic       exc;
    logic [9:0] exp;
  } step_t;

  step_t      seq[$];
  logic [9:0] exp_q[$];
  logic [9:0] got, exp_v;
  int         n_assert = 0;
  int         n_fail   = 0;

  function automatic step_t mk(input logic [4:0] rs, rt, input logic br, exr,
                               input logic [4:0] exw, input logic memr,
                               input logic [4:0] memw, input logic div, exc,
                               input logic [9:0] exp);
    step_t s;
    s.rs = rs; s.rt = rt; s.br = br; s.exr = exr; s.exw = exw;
    s.memr = memr; s.memw = memw; s.div = div; s.exc = exc; s.exp = exp;
    return s;
  endfunction

  task automatic drive(input step_t s);
    id_rs_i     = s.rs;
    id_rt_i     = s.rt;
    id_branch_i = s.br;
    ex_rmem_i   = s.exr;
    ex_waddr_i  = s.exw;
    mem_rmem_i  = s.memr;
    mem_waddr_i = s.memw;
    ex_div_i    = s.div;
    exc_valid_i = s.exc;
  endtask

  // Full divide starting from RUN: entry + (DIV_N-1) busy cycles, done, idle.
  task automatic add_divide();
    for (int i = 0; i < DIV_N; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DIVB));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DONE));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
  endtask

  task automatic test_reset();
    #1;
    got = outs;
    n_assert++;
    if (got !== E_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: outs=%b expected=%b", got, E_IDLE);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    got = outs;
    n_assert++;
    if (got !== E_IDLE) begin
      n_fail++;
      $display("FAIL reset_held: outs=%b expected=%b", got, E_IDLE);
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_load_use();
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0, E_HAZ));   // rs matches load dest
    seq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, E_IDLE));  // $zero never hazards
    seq.push_back(mk(1, 7, 0, 1, 7, 0, 0, 0, 0, E_HAZ));   // rt match
    seq.push_back(mk(1, 7, 0, 0, 7, 0, 0, 0, 0, E_IDLE));  // not a load
    seq.push_back(mk(3, 4, 0, 1, 9, 0, 0, 0, 0, E_IDLE));  // no match
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL load_use[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
  endtask

  task automatic test_branch();
    seq.push_back(mk(2, 8, 1, 0, 0, 1, 8, 0, 0, E_HAZ));   // rt matches MEM load
    seq.push_back(mk(2, 8, 1, 0, 0, 0, 8, 0, 0, E_IDLE));  // MEM not a load
    seq.push_back(mk(2, 8, 0, 0, 0, 1, 8, 0, 0, E_IDLE));  // not a branch
    seq.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, E_IDLE));  // $zero
    seq.push_back(mk(6, 6, 1, 1, 6, 1, 6, 0, 0, E_HAZ));   // both hazards at once
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
  endtask

  task automatic test_divide();
    int stall_ex_cnt;
    stall_ex_cnt = 0;
    // Entry with a load-use hazard present too: divide must win.
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 1, 0, E_DIVB));
    for (int i = 1; i < DIV_N; i++) seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 1, 0, E_DIVB));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DONE));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0, E_HAZ));   // back in RUN
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      if (got[7]) stall_ex_cnt++;
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL divide[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
    n_assert++;
    if (stall_ex_cnt != DIV_N) begin
      n_fail++;
      $display("FAIL divide_stall_len: cycles=%0d expected=%0d", stall_ex_cnt, DIV_N);
    end
  endtask

  task automatic test_exc_in_div();
    // Entry plus 10 busy cycles (counter 0..9); exception lands at counter 10.
    for (int i = 0; i < 11; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DIVB));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_EXC));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FLSH));
    for (int i = 0; i < 25; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    add_divide();  // a fresh divide must take the full length again
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL exc_in_div[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
  endtask

  task automatic test_exc_priority();
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 1, E_EXC));   // exc over load-use
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0, E_FLSH));  // FLUSH ignores hazard
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 1, E_EXC));   // exc again from FLUSH
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0, E_FLSH));
    seq.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0, E_HAZ));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_EXC));   // exc over divide entry
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FLSH));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL exc_priority[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
  endtask

  task automatic test_reset_mid_div();
    // Entry plus 20 busy cycles leaves the counter at 20.
    for (int i = 0; i < 21; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_DIVB));
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rst_div_pre[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
    got = outs;
    n_assert++;
    if (got !== E_DIVB) begin
      n_fail++;
      $display("FAIL rst_div_busy: outs=%b expected=%b", got, E_DIVB);
    end
    rst_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    #1;
    got = outs;
    n_assert++;
    if (got !== E_IDLE) begin
      n_fail++;
      $display("FAIL rst_div_async: outs=%b expected=%b", got, E_IDLE);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 20; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    add_divide();
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      exp_q.push_back(seq[i].exp);
      @(negedge clk_i);
      got   = outs;
      exp_v = exp_q.pop_front();
      n_assert++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rst_div_post[%0d]: outs=%b expected=%b", i, got, exp_v);
      end
      @(posedge clk_i);
      #1;
    end
    seq.delete();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_divide();
    test_exc_in_div();
    test_exc_priority();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
